// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the multiplexed seven-segment controller.
package seg7_pkg;

  localparam logic [1:0] SEG_ADDR_LO = 2'd0;
  localparam logic [1:0] SEG_ADDR_HI = 2'd1;
  localparam logic [1:0] SEG_ADDR_EN = 2'd2;
  localparam logic [1:0] SEG_ADDR_DP = 2'd3;

  localparam logic [7:0] DIG_BLANK = 8'hFF;
  localparam logic [7:0] Y_BLANK   = 8'hFF;

  // Active-high gfedcba pattern for one hex digit; the pins invert it.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high gfedcba segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] segs
);

  always_comb begin
    segs = hex7(nib);
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 8-digit multiplexed seven-segment controller with active-low anode/segment pins.
// Optional digit blinking is built in when SEG_BLINK_EN is defined.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV = 64
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        segwrite,
  input  logic        segcs,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  DIG,
  output logic [7:0]  Y
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]   nibbles;
  logic [7:0]    en_mask;
  logic [7:0]    dp_mask;
  logic [PW-1:0] pre_cnt;
  logic [2:0]    idx;
  logic          slot_tick;
  logic          wr_en;
  logic [3:0]    sel_nib;
  logic [6:0]    sel_segs;
  logic          lit;
  logic          blink_off;

  assign wr_en     = segcs && segwrite;
  assign slot_tick = (pre_cnt == PW'(SCAN_DIV - 1));
  assign sel_nib   = nibbles[{idx, 2'b00} +: 4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nibbles <= '0;
      en_mask <= 8'hFF;
      dp_mask <= '0;
    end else if (wr_en) begin
      case (segaddr)
        SEG_ADDR_LO: nibbles[15:0]  <= segwdata;
        SEG_ADDR_HI: nibbles[31:16] <= segwdata;
        SEG_ADDR_EN: en_mask        <= segwdata[7:0];
        default:     dp_mask        <= segwdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (slot_tick) begin
      pre_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [7:0]    blink_mask;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_mask <= '0;
    end else if (wr_en && segaddr == SEG_ADDR_DP) begin
      blink_mask <= segwdata[15:8];
    end
  end

  // Phase flips after every BLINK_DIV slot advances; phase 1 blanks masked digits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_tick) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blink_off = blink_phase && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  assign lit = en_mask[idx] && !blink_off;

  seg7_hex_decode u_hex_decode (
    .nib  (sel_nib),
    .segs (sel_segs)
  );

  // Outputs follow the current slot one cycle later so both pins change together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      DIG <= DIG_BLANK;
      Y   <= Y_BLANK;
    end else if (lit) begin
      DIG <= ~(8'b0000_0001 << idx);
      Y   <= {~dp_mask[idx], ~sel_segs};
    end else begin
      DIG <= DIG_BLANK;
      Y   <= Y_BLANK;
    end
  end

endmodule
